ct_cmd_sequencer: RTL

//  Drive side of the CT latch interface. Accepts WIDTH-bit target words on a valid/ready input.

---
 rtl/ct_pkg.sv | 20 ++
 rtl/ct_cmd_encode.sv | 33 +++
 rtl/ct_cmd_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ct_pkg                                                           |
// | Brief   : CT latch command encodings and sequencer state codes.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ct_pkg;

  localparam logic [1:0] CT_TOGGLE = 2'b00;
  localparam logic [1:0] CT_RESET  = 2'b01;
  localparam logic [1:0] CT_SET    = 2'b10;
  localparam logic [1:0] CT_HOLD   = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ct_cmd_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ct_cmd_encode                                                    |
// | Brief   : Chooses the {c,t} command that drives a CT latch to a target bit |
// |           given the current latch model.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ct_cmd_encode
  import ct_pkg::*;
#(
  parameter int unsigned PREFER_TOGGLE = 1
) (
  input  logic       target,
  input  logic       model_q,
  input  logic       model_known,
  output logic [1:0] cmd
);

  always_comb begin
    cmd = CT_HOLD;
    if (!model_known) begin
      cmd = target ? CT_SET : CT_RESET;
    end else if (target == model_q) begin
      cmd = CT_HOLD;
    end else if (PREFER_TOGGLE != 0) begin
      cmd = CT_TOGGLE;
    end else begin
      cmd = target ? CT_SET : CT_RESET;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ct_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ct_cmd_sequencer                                                 |
// | Brief   : Serialises target words MSB first into CT latch commands using   |
// |           an internal latch model. Define CT_FEEDBACK_CHECK_EN to add the   |
// |           q_fb feedback checker and sticky err_mismatch output.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ct_cmd_sequencer
  import ct_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PREFER_TOGGLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr_model,
  output logic             cmd_c,
  output logic             cmd_t,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_last,
  output logic             busy
`ifdef CT_FEEDBACK_CHECK_EN
  ,
  input  logic             q_fb,
  output logic             err_mismatch
`endif
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             cmd_c_q, cmd_c_d;
  logic             cmd_t_q, cmd_t_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_last_q, cmd_last_d;
  logic             model_bit_q, model_bit_d;
  logic             model_known_q, model_known_d;

  logic       hs;
  logic       load;
  logic       next_bit;
  logic [1:0] enc_cmd;

  assign hs       = cmd_valid_q & cmd_ready;
  assign in_ready = (state_q == S_IDLE) | (hs & cmd_last_q);
  assign load     = in_valid & in_ready;
  assign next_bit = load ? in_data[WIDTH-1] : shreg_q[WIDTH-2];

  // Next command is encoded against the model as it will be after this edge.
  always_comb begin
    model_bit_d   = model_bit_q;
    model_known_d = model_known_q;
    if (hs) begin
      model_bit_d   = shreg_q[WIDTH-1];
      model_known_d = 1'b1;
    end
    if (clr_model) begin
      model_known_d = 1'b0;
    end
  end

  ct_cmd_encode #(
    .PREFER_TOGGLE(PREFER_TOGGLE)
  ) u_encode (
    .target     (next_bit),
    .model_q    (model_bit_d),
    .model_known(model_known_d),
    .cmd        (enc_cmd)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_c_d     = cmd_c_q;
    cmd_t_d     = cmd_t_q;
    cmd_valid_d = cmd_valid_q;
    cmd_last_d  = cmd_last_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d              = S_EMIT;
          shreg_d              = in_data;
          bit_cnt_d            = '0;
          cmd_valid_d          = 1'b1;
          cmd_last_d           = 1'b0;
          {cmd_c_d, cmd_t_d}   = enc_cmd;
        end
      end
      S_EMIT: begin
        if (load) begin
          shreg_d              = in_data;
          bit_cnt_d            = '0;
          cmd_valid_d          = 1'b1;
          cmd_last_d           = 1'b0;
          {cmd_c_d, cmd_t_d}   = enc_cmd;
        end else if (hs && !cmd_last_q) begin
          shreg_d              = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d            = bit_cnt_q + CNT_W'(1);
          cmd_last_d           = ((bit_cnt_q + CNT_W'(1)) == LAST_IDX);
          {cmd_c_d, cmd_t_d}   = enc_cmd;
        end else if (hs) begin
          state_d              = S_IDLE;
          cmd_valid_d          = 1'b0;
          cmd_last_d           = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      cmd_c_q       <= 1'b1;
      cmd_t_q       <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_last_q    <= 1'b0;
      model_bit_q   <= 1'b0;
      model_known_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      cmd_c_q       <= cmd_c_d;
      cmd_t_q       <= cmd_t_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_last_q    <= cmd_last_d;
      model_bit_q   <= model_bit_d;
      model_known_q <= model_known_d;
    end
  end

  assign cmd_c     = cmd_c_q;
  assign cmd_t     = cmd_t_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_last  = cmd_last_q;
  assign busy      = (state_q != S_IDLE);

`ifdef CT_FEEDBACK_CHECK_EN
  // Latch Q is compared one cycle after the command that should have set it.
  logic hs_dly_q;
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (hs_dly_q && model_known_q && (q_fb != model_bit_q)) begin
      err_d = 1'b1;
    end
    if (clr_model) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_dly_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hs_dly_q <= hs;
      err_q    <= err_d;
    end
  end

  assign err_mismatch = err_q;
`endif

endmodule
`default_nettype wire
